rv32v_element_sequencer: RTL and testbench

- Walks the element index space of one decoded vector instruction, from vstart up to vl-1, two elements per cycle (lane 0 / lane 1).
- Per lane, emits source and destination register-group offsets and a masked write enable.
- Sits between vector decode and execute. Started by decode_done; holds on execute stall; reports busy/done back to the hazard and commit logic.

---
 rtl/rv32v_element_sequencer_if.sv | 47 ++++
 rtl/rv32v_element_sequencer.sv | 174 +++++++++++++++++
 tb/tb_rv32v_element_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32v_element_sequencer_if.sv
// Decode/execute-facing signal bundle of the vector element sequencer.
// The master side drives instruction fields and flow control; the slave side is the sequencer.
interface rv32v_element_sequencer_if #(
  parameter int unsigned VLMAX = 128
);
  localparam int unsigned IW = $clog2(VLMAX) + 1;

  logic             start;
  logic [31:0]      vl;
  logic [31:0]      vstart;
  logic [1:0]       sew;
  logic             vd_widen;
  logic             vd_narrow;
  logic             is_masked;
  logic [VLMAX-1:0] v0_mask;
  logic             stall;
  logic             flush;

  logic             busy;
  logic             valid0;
  logic             valid1;
  logic [IW-1:0]    eidx0;
  logic [IW-1:0]    eidx1;
  logic [2:0]       src_reg0;
  logic [2:0]       src_reg1;
  logic [3:0]       src_elem0;
  logic [3:0]       src_elem1;
  logic [2:0]       dst_reg0;
  logic [2:0]       dst_reg1;
  logic [3:0]       dst_elem0;
  logic [3:0]       dst_elem1;
  logic             wen0;
  logic             wen1;
  logic             done;

  modport master (
    output start, vl, vstart, sew, vd_widen, vd_narrow, is_masked, v0_mask, stall, flush,
    input  busy, valid0, valid1, eidx0, eidx1, src_reg0, src_reg1, src_elem0, src_elem1,
           dst_reg0, dst_reg1, dst_elem0, dst_elem1, wen0, wen1, done
  );

  modport slave (
    input  start, vl, vstart, sew, vd_widen, vd_narrow, is_masked, v0_mask, stall, flush,
    output busy, valid0, valid1, eidx0, eidx1, src_reg0, src_reg1, src_elem0, src_elem1,
           dst_reg0, dst_reg1, dst_elem0, dst_elem1, wen0, wen1, done
  );
endinterface

// File: rtl/rv32v_element_sequencer.sv
// Walks vstart..vl-1 of one vector instruction two elements per cycle, producing per-lane
// register-group offsets and masked write enables for the execute stage.
module rv32v_element_sequencer #(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned VLMAX = 128
) (
  input logic                 CLK,
  input logic                 RST,
  rv32v_element_sequencer_if.slave bus
);
  localparam int unsigned IW = $clog2(VLMAX) + 1;
  localparam int unsigned MW = $clog2(VLMAX);
  localparam logic [2:0]  LogEpr0 = 3'($clog2(VLEN / 8));

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [IW-1:0] clamp(input logic [31:0] x);
    if (x[IW-1:0] > IW'(VLMAX)) return IW'(VLMAX);
    return x[IW-1:0];
  endfunction

  // Effective element width code; widen/narrow beyond 32 bits saturates at 32.
  function automatic logic [1:0] eew(input logic [1:0] s, input logic dbl);
    logic [2:0] w;
    w = {1'b0, s} + {2'b0, dbl};
    return (w > 3'd2) ? 2'd2 : w[1:0];
  endfunction

  state_e           state_q;
  logic             busy_q, done_q;
  logic [IW-1:0]    vl_q, e_q;
  logic [1:0]       sew_q;
  logic             widen_q, narrow_q, masked_q;
  logic [VLMAX-1:0] mask_q;

  logic             in_idle, go, lane_ld, lane_clr, last;
  logic [IW-1:0]    cfg_vl, e_nxt, lo_s, lo_d;
  logic [1:0]       cfg_sew, ws, wd;
  logic             cfg_widen, cfg_narrow, cfg_masked;
  logic [VLMAX-1:0] cfg_mask;
  logic [2:0]       sh_s, sh_d;

  logic [IW-1:0]    n_eidx [2];
  logic [2:0]       n_sreg [2], n_dreg [2];
  logic [3:0]       n_selem [2], n_delem [2];
  logic [1:0]       n_valid, n_wen;

  logic [IW-1:0]    eidx_q [2];
  logic [2:0]       sreg_q [2], dreg_q [2];
  logic [3:0]       selem_q [2], delem_q [2];
  logic [1:0]       valid_q, wen_q;

  // In IDLE the next pair is computed from live decode fields, otherwise from captured ones.
  always_comb begin
    in_idle    = (state_q == StIdle);
    cfg_vl     = in_idle ? clamp(bus.vl) : vl_q;
    cfg_sew    = in_idle ? bus.sew : sew_q;
    cfg_widen  = in_idle ? bus.vd_widen : widen_q;
    cfg_narrow = in_idle ? bus.vd_narrow : narrow_q;
    cfg_masked = in_idle ? bus.is_masked : masked_q;
    cfg_mask   = in_idle ? bus.v0_mask : mask_q;
    e_nxt      = in_idle ? clamp(bus.vstart) : e_q + IW'(2);
    ws         = eew(cfg_sew, cfg_narrow);
    wd         = eew(cfg_sew, cfg_widen);
    sh_s       = LogEpr0 - {1'b0, ws};
    sh_d       = LogEpr0 - {1'b0, wd};
    lo_s       = (IW'(1) << sh_s) - IW'(1);
    lo_d       = (IW'(1) << sh_d) - IW'(1);
    go         = in_idle ? bus.start : ((state_q == StRun) && !bus.flush && !bus.stall);
    last       = (e_nxt >= cfg_vl);
    lane_ld    = go && !last;
    lane_clr   = (state_q == StRun) && (bus.flush || (!bus.stall && last));
    for (int l = 0; l < 2; l++) begin
      n_eidx[l]  = e_nxt + IW'(l);
      n_valid[l] = (n_eidx[l] < cfg_vl);
      n_sreg[l]  = 3'(n_eidx[l] >> sh_s);
      n_selem[l] = 4'(n_eidx[l] & lo_s);
      n_dreg[l]  = 3'(n_eidx[l] >> sh_d);
      n_delem[l] = 4'(n_eidx[l] & lo_d);
      n_wen[l]   = n_valid[l] & (~cfg_masked | cfg_mask[n_eidx[l][MW-1:0]]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vl_q     <= '0;
      e_q      <= '0;
      sew_q    <= '0;
      widen_q  <= 1'b0;
      narrow_q <= 1'b0;
      masked_q <= 1'b0;
      mask_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            vl_q     <= cfg_vl;
            sew_q    <= bus.sew;
            widen_q  <= bus.vd_widen;
            narrow_q <= bus.vd_narrow;
            masked_q <= bus.is_masked;
            mask_q   <= bus.v0_mask;
            e_q      <= e_nxt;
            state_q  <= last ? StDone : StRun;
            done_q   <= last;
            busy_q   <= !last;
          end
        end
        StRun: begin
          if (bus.flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!bus.stall) begin
            e_q <= e_nxt;
            if (last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || lane_clr) begin
      valid_q <= '0;
      wen_q   <= '0;
      for (int l = 0; l < 2; l++) begin
        eidx_q[l]  <= '0;
        sreg_q[l]  <= '0;
        selem_q[l] <= '0;
        dreg_q[l]  <= '0;
        delem_q[l] <= '0;
      end
    end else if (lane_ld) begin
      valid_q <= n_valid;
      wen_q   <= n_wen;
      for (int l = 0; l < 2; l++) begin
        eidx_q[l]  <= n_eidx[l];
        sreg_q[l]  <= n_sreg[l];
        selem_q[l] <= n_selem[l];
        dreg_q[l]  <= n_dreg[l];
        delem_q[l] <= n_delem[l];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.valid0    = valid_q[0];
  assign bus.valid1    = valid_q[1];
  assign bus.wen0      = wen_q[0];
  assign bus.wen1      = wen_q[1];
  assign bus.eidx0     = eidx_q[0];
  assign bus.eidx1     = eidx_q[1];
  assign bus.src_reg0  = sreg_q[0];
  assign bus.src_reg1  = sreg_q[1];
  assign bus.src_elem0 = selem_q[0];
  assign bus.src_elem1 = selem_q[1];
  assign bus.dst_reg0  = dreg_q[0];
  assign bus.dst_reg1  = dreg_q[1];
  assign bus.dst_elem0 = delem_q[0];
  assign bus.dst_elem1 = delem_q[1];
endmodule

// File: tb/tb_rv32v_element_sequencer.sv
// Table-driven scoreboard bench for the vector element sequencer, with hand-written
// flush, reset and start-during-reset sequences.
module tb_rv32v_element_sequencer;
  typedef struct {
    logic [31:0]  vl;
    logic [31:0]  vstart;
    logic [1:0]   sew;
    logic         widen;
    logic         narrow;
    logic         masked;
    logic [127:0] mask;
    int           stall_at;
    int           stall_len;
    int           exp_runs;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  logic [47:0] sb_q [$];

  rv32v_element_sequencer_if #(.VLMAX(128)) bus ();

  rv32v_element_sequencer #(.VLEN(128), .VLMAX(128)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int vl, input int vs, input int sew, input bit wid,
                              input bit nar, input bit msk, input logic [127:0] m,
                              input int sat, input int slen, input int runs);
    vec_t v;
    v.vl = vl; v.vstart = vs; v.sew = 2'(sew); v.widen = wid; v.narrow = nar;
    v.masked = msk; v.mask = m; v.stall_at = sat; v.stall_len = slen; v.exp_runs = runs;
    return v;
  endfunction

  function automatic int clampv(input logic [31:0] x);
    int t;
    t = int'(x[7:0]);
    return (t > 128) ? 128 : t;
  endfunction

  function automatic int wcode(input logic [1:0] s, input bit dbl);
    int w;
    w = int'(s) + (dbl ? 1 : 0);
    return (w > 2) ? 2 : w;
  endfunction

  // Elements per register for width code w, by plain division.
  function automatic int epr(input int w);
    return 128 / (8 << w);
  endfunction

  function automatic logic [47:0] exp_pair(input vec_t v, input int e);
    int   vlc, es, ed, idx;
    logic va [2];
    logic we [2];
    logic [13:0] off [2];
    vlc = clampv(v.vl);
    es  = epr(wcode(v.sew, v.narrow));
    ed  = epr(wcode(v.sew, v.widen));
    for (int l = 0; l < 2; l++) begin
      idx    = e + l;
      va[l]  = (idx < vlc);
      we[l]  = va[l] && (!v.masked || v.mask[idx % 128]);
      off[l] = {3'(idx / es), 4'(idx % es), 3'(idx / ed), 4'(idx % ed)};
    end
    return {va[0], va[1], 8'(e), 8'(e + 1), off[0], off[1], we[0], we[1]};
  endfunction

  function automatic logic [47:0] act_pair();
    return {bus.valid0, bus.valid1, bus.eidx0, bus.eidx1,
            bus.src_reg0, bus.src_elem0, bus.dst_reg0, bus.dst_elem0,
            bus.src_reg1, bus.src_elem1, bus.dst_reg1, bus.dst_elem1, bus.wen0, bus.wen1};
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int  k;
    bit  seen_done;
    bit  st;
    sb_q.delete();
    for (int e = clampv(v.vstart); e < clampv(v.vl); e += 2) sb_q.push_back(exp_pair(v, e));
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.vl = v.vl; bus.vstart = v.vstart; bus.sew = v.sew;
    bus.vd_widen = v.widen; bus.vd_narrow = v.narrow; bus.is_masked = v.masked;
    bus.v0_mask = v.mask;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    k = 0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      st = (v.stall_len > 0) && (k + 1 >= v.stall_at) && (k + 1 < v.stall_at + v.stall_len);
      bus.stall = st;
      @(negedge CLK);
      if (bus.busy) begin
        k++;
        if (sb_q.size() == 0) begin
          check($sformatf("vec%0d_extra_pair", n), act_pair(), 48'h0);
        end else begin
          check($sformatf("vec%0d_pair%0d", n, k), act_pair(), sb_q[0]);
          if (!st) void'(sb_q.pop_front());
        end
      end else if (bus.done) begin
        seen_done = 1'b1;
        check($sformatf("vec%0d_done_lanes_zero", n), act_pair(), 48'h0);
      end else begin
        check($sformatf("vec%0d_early_idle", n), {bus.busy, bus.done}, 2'b01);
      end
      @(posedge CLK); #1;
    end
    bus.stall = 1'b0;
    check($sformatf("vec%0d_done_seen", n), seen_done, 1'b1);
    check($sformatf("vec%0d_run_cycles", n), k, v.exp_runs);
    check($sformatf("vec%0d_sb_empty", n), sb_q.size(), 0);
    @(negedge CLK);
    check($sformatf("vec%0d_done_pulse", n), {bus.busy, bus.done}, 2'b00);
  endtask

  // Abort a vl=20 run in its second RUN cycle by flush or reset.
  task automatic abort_test(input bit use_rst);
    string tag;
    tag = use_rst ? "rst" : "flush";
    @(posedge CLK); #1;
    bus.start = 1'b1; bus.vl = 20; bus.vstart = 0; bus.sew = 2'd0;
    bus.vd_widen = 1'b0; bus.vd_narrow = 1'b0; bus.is_masked = 1'b0;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    @(negedge CLK);
    check({tag, "_run1_busy"}, bus.busy, 1'b1);
    @(posedge CLK); #1;
    if (use_rst) RST = 1'b1; else bus.flush = 1'b1;
    @(negedge CLK);
    check({tag, "_run2_eidx"}, {bus.eidx0, bus.eidx1}, {8'd2, 8'd3});
    @(posedge CLK); #1;
    RST = 1'b0; bus.flush = 1'b0;
    @(negedge CLK);
    check({tag, "_idle"}, {bus.busy, bus.valid0, bus.valid1, bus.done}, 4'b0000);
    @(posedge CLK); #1;
    @(negedge CLK);
    check({tag, "_no_done"}, {bus.busy, bus.done}, 2'b00);
    run_vec(use_rst ? 21 : 20, mk(2, 0, 1, 0, 0, 0, 128'h0, 0, 0, 1));
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = mk(5, 0, 2, 0, 0, 0, 128'h0, 0, 0, 3);
    tbl[1] = mk(8, 0, 0, 1, 0, 0, 128'h0, 0, 0, 4);
    tbl[2] = mk(4, 0, 0, 0, 0, 1, 128'ha, 0, 0, 2);
    tbl[3] = mk(6, 0, 2, 0, 0, 0, 128'h0, 2, 3, 6);
    tbl[4] = mk(7, 7, 0, 0, 0, 0, 128'h0, 0, 0, 0);
    tbl[5] = mk(9, 3, 1, 0, 1, 1, 128'h1a5, 0, 0, 3);
    tbl[6] = mk(300, 0, 1, 1, 0, 1, {4{32'h9e3779b9}}, 5, 2, 24);
    tbl[7] = mk(128, 200, 0, 0, 0, 0, 128'h0, 0, 0, 0);
    tbl[8] = mk(10, 1, 2, 1, 0, 0, 128'h0, 0, 0, 5);

    RST = 1'b1;
    bus.start = 1'b0; bus.vl = '0; bus.vstart = '0; bus.sew = '0; bus.vd_widen = 1'b0;
    bus.vd_narrow = 1'b0; bus.is_masked = 1'b0; bus.v0_mask = '0; bus.stall = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("reset_lanes", act_pair(), 48'h0);
    check("reset_busy_done", {bus.busy, bus.done}, 2'b00);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    abort_test(1'b0);
    abort_test(1'b1);

    // A start coinciding with reset must be dropped.
    @(posedge CLK); #1;
    RST = 1'b1; bus.start = 1'b1; bus.vl = 4; bus.vstart = 0;
    @(posedge CLK); #1;
    RST = 1'b0; bus.start = 1'b0;
    @(negedge CLK);
    check("rst_start_dropped", {bus.busy, bus.done}, 2'b00);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("rst_start_still_idle", {bus.busy, bus.done, bus.valid0}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
